// File: rtl/adder_defs.sv
// adder_defs: mode encoding and slice-width helpers shared by the pipelined adder.
package adder_defs;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit slicing_ok(input int width, input int stages);
        return stages >= 1 && stages <= width && width % stages == 0;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: one carry-chain slice plus its pipeline register; operands and
// the partial result ride along so later slices can finish the add.
module adder_slice
    import adder_defs::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int K      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_bb,
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_bb,
    output logic [WIDTH-1:0] o_r,
    output logic             o_c,
    output logic             o_sub
);

    localparam int W = slice_width(WIDTH, STAGES);

    logic [W:0]       w_add;
    logic [WIDTH-1:0] w_r;
    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bb;
    logic [WIDTH-1:0] r_r;
    logic             r_c;
    logic             r_sub;

    assign w_add = {1'b0, i_a[K*W +: W]} + {1'b0, i_bb[K*W +: W]} + {{W{1'b0}}, i_c};

    always_comb begin
        w_r = i_r;
        w_r[K*W +: W] = w_add[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_bb    <= '0;
            r_r     <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_a     <= i_a;
            r_bb    <= i_bb;
            r_r     <= w_r;
            r_c     <= w_add[W];
            r_sub   <= i_sub;
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_bb    = r_bb;
    assign o_r     = r_r;
    assign o_c     = r_c;
    assign o_sub   = r_sub;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced add/subtract with valid/ready flow control,
// optional unsigned saturation and signed-overflow flag.
module pipelined_adder
    import adder_defs::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_slicing
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    logic             w_adv;
    logic             w_v   [0:STAGES];
    logic [WIDTH-1:0] w_a   [0:STAGES];
    logic [WIDTH-1:0] w_bb  [0:STAGES];
    logic [WIDTH-1:0] w_r   [0:STAGES];
    logic             w_c   [0:STAGES];
    logic             w_s   [0:STAGES];
    logic             w_hi;
    logic             w_lo;
    logic             w_unused;

    // The whole pipe moves as one; bubbles are kept, never collapsed.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_v[0]  = in_valid;
    assign w_a[0]  = a;
    assign w_bb[0] = (sub == MODE_SUB) ? ~b : b;
    assign w_r[0]  = '0;
    assign w_c[0]  = (sub == MODE_SUB) ? 1'b1 : cin;
    assign w_s[0]  = sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .K     (k)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_adv),
            .i_valid(w_v[k]),
            .i_a    (w_a[k]),
            .i_bb   (w_bb[k]),
            .i_r    (w_r[k]),
            .i_c    (w_c[k]),
            .i_sub  (w_s[k]),
            .o_valid(w_v[k+1]),
            .o_a    (w_a[k+1]),
            .o_bb   (w_bb[k+1]),
            .o_r    (w_r[k+1]),
            .o_c    (w_c[k+1]),
            .o_sub  (w_s[k+1])
        );
    end

    // Saturation only clamps the result field; carry and ovf stay raw.
    assign w_hi = SAT && (w_s[STAGES] == MODE_ADD) && w_c[STAGES];
    assign w_lo = SAT && (w_s[STAGES] == MODE_SUB) && !w_c[STAGES];

    assign out_valid = w_v[STAGES];
    assign sum       = {w_c[STAGES], w_hi ? {WIDTH{1'b1}} : w_lo ? {WIDTH{1'b0}} : w_r[STAGES]};
    assign ovf       = (w_a[STAGES][MSB] == w_bb[STAGES][MSB]) && (w_r[STAGES][MSB] != w_a[STAGES][MSB]);

    assign w_unused = ^{w_a[STAGES], w_bb[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of the pipelined adder (8/2 wrap,
// 8/2 saturate sharing one stream, and a 32/4 instance) against an arithmetic model.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, ovf;
    logic [8:0] sum;
    logic       s_in_ready, s_out_valid, s_ovf;
    logic [8:0] s_sum;

    logic        wv = 1'b0, wcin = 1'b0, wsub = 1'b0, wordy = 1'b1;
    logic [31:0] wa = '0, wb = '0;
    logic        win_ready, wout_valid, wovf;
    logic [32:0] wsum;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(2), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(2), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .ovf(s_ovf)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4), .SAT(1'b0)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(wv), .in_ready(win_ready), .a(wa), .b(wb),
        .cin(wcin), .sub(wsub), .out_valid(wout_valid), .out_ready(wordy), .sum(wsum), .ovf(wovf)
    );

    typedef struct packed {
        logic       ovf;
        logic [8:0] sum;
        logic [8:0] ssum;
    } exp_t;

    exp_t       q[$];
    int         errors = 0, checks = 0, retired = 0;
    logic       acc = 1'b0, held_stall = 1'b0;
    logic [8:0] held_sum = '0;

    // Plain integer arithmetic: unsigned result with carry/no-borrow, signed range for ovf.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        int   ux, uy, sx, sy, full, sr, r;
        logic co;
        exp_t e;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        full = s ? ux - uy : ux + uy + int'(c);
        sr = s ? sx - sy : sx + sy + int'(c);
        co = s ? (full >= 0) : (full > 255);
        r = (full + 256) % 256;
        e.sum = {co, 8'(r)};
        e.ovf = (sr > 127) || (sr < -128);
        e.ssum = {co, (!s && co) ? 8'hFF : (s && !co) ? 8'h00 : 8'(r)};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic s, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid = v; a = x; b = y; cin = c; sub = s; out_ready = ordy;
        #1;
        if (held_stall) chk("hold_sum", sum, held_sum);
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_sat_in_ready", s_in_ready, 1'b0);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_beat", out_valid, 1'b0);
            else begin
                e = q.pop_front();
                retired++;
                chk("sum", sum, e.sum);
                chk("ovf", ovf, e.ovf);
                chk("sat_valid", s_out_valid, 1'b1);
                chk("sat_sum", s_sum, e.ssum);
                chk("sat_ovf", s_ovf, e.ovf);
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(x, y, c, s));
        held_stall = out_valid && !out_ready;
        held_sum = sum;
    endtask

    task automatic idle(input int n, input logic ordy);
        repeat (n) tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy);
    endtask

    task automatic one(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic s, input logic [8:0] e_sum, input logic [8:0] e_ssum, input logic e_ovf);
        tick(1'b1, x, y, c, s, 1'b1);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk({tag, "_lat2"}, out_valid, 1'b1);
        chk({tag, "_sum"}, sum, e_sum);
        chk({tag, "_sat"}, s_sum, e_ssum);
        chk({tag, "_ovf"}, ovf, e_ovf);
    endtask

    task automatic wone(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [32:0] e_sum, input logic e_ovf);
        @(negedge clk);
        wv = 1'b1; wa = x; wb = y; wsub = s; wcin = 1'b0; wordy = 1'b1;
        #1;
        chk({tag, "_ready"}, win_ready, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            wv = 1'b0;
            #1;
            chk({tag, "_lat"}, wout_valid, i == 4);
        end
        chk({tag, "_sum"}, wsum, e_sum);
        chk({tag, "_ovf"}, wovf, e_ovf);
    endtask

    initial begin
        logic       pv, pc, ps;
        logic [7:0] px, py;
        int         sent, r0;
        logic [7:0] sx [0:5];
        logic [7:0] sy [0:5];

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 9'h000);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_sat_sum", s_sum, 9'h000);
        chk("rst_wide_valid", wout_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        one("t1", 8'd1, 8'd10, 1'b0, 1'b0, 9'h00B, 9'h00B, 1'b0);
        one("t2", 8'd255, 8'd255, 1'b0, 1'b0, 9'h1FE, 9'h1FF, 1'b0);
        one("t3", 8'd10, 8'd99, 1'b0, 1'b1, 9'h0A7, 9'h000, 1'b0);
        one("t4a", 8'd100, 8'd100, 1'b0, 1'b0, 9'h0C8, 9'h0C8, 1'b1);
        one("t4b", 8'h80, 8'h80, 1'b0, 1'b0, 9'h100, 9'h1FF, 1'b1);
        one("cin_add", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100, 9'h1FF, 1'b0);
        one("cin_ign", 8'd5, 8'd5, 1'b1, 1'b1, 9'h100, 9'h100, 1'b0);
        one("sub_min", 8'h00, 8'h80, 1'b0, 1'b1, 9'h080, 9'h000, 1'b1);

        wone("w_carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 33'h1_0000_0000, 1'b0);
        wone("w_sub", 32'd5, 32'd7, 1'b1, 33'h0_FFFF_FFFE, 1'b0);
        wone("w_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 33'h0_8000_0000, 1'b1);

        // Six back-to-back beats with out_ready dropped for three cycles mid-stream.
        for (int i = 0; i < 6; i++) begin
            sx[i] = 8'(37 * i + 200);
            sy[i] = 8'(91 * i + 17);
        end
        r0 = retired;
        sent = 0;
        for (int cyc = 0; cyc < 30 && sent < 6; cyc++) begin
            tick(1'b1, sx[sent], sy[sent], 1'b0, sent[0], !(cyc >= 3 && cyc <= 5));
            if (acc) sent++;
        end
        chk("stream_sent", sent, 6);
        idle(4, 1'b1);
        chk("stream_retired", retired - r0, 6);
        chk("stream_drained", q.size(), 0);

        pv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                px = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                py = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                pc = 1'($urandom);
                ps = 1'($urandom);
            end
            tick(pv, px, py, pc, ps, $urandom_range(0, 4) != 0);
            if (acc) pv = 1'b0;
        end
        idle(5, 1'b1);
        chk("random_drained", q.size(), 0);

        // Two beats in flight, then a one-cycle async reset.
        tick(1'b1, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_sum", sum, 9'h000);
        chk("rst_mid_sat_valid", s_out_valid, 1'b0);
        q.delete();
        held_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        r0 = retired;
        idle(4, 1'b1);
        chk("no_stale_valid", out_valid, 1'b0);
        chk("no_stale_retired", retired - r0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
